dff_pipe_reg: RTL and testbench

//   Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage

---
 rtl/dff_pipe_reg.sv | 92 +++++++++
 tb/tb_dff_pipe_reg.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dff_pipe_reg.sv
// dff_pipe_reg: WIDTH-bit, DEPTH-stage registered delay line with per-stage
// valid, global stall (en), synchronous flush and an occupancy counter.
// Optional feature macro: DFF_PIPE_PARITY_EN adds a per-stage even-parity bit,
// the par_inject input and the parity_err output.
module dff_pipe_reg #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef DFF_PIPE_PARITY_EN
    ,
    input  logic                       par_inject,
    output logic                       parity_err
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [CW-1:0]    count_q;

    // Valid chain: cleared on reset/flush, shifted when enabled, held otherwise.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q <= '0;
        end else if (en) begin
            valid_q[0] <= in_valid;
            for (int k = 1; k < DEPTH; k++) begin
                valid_q[k] <= valid_q[k-1];
            end
        end
    end

    // Data chain: bubbles still shift their data so stage contents always
    // reflect in_data as sampled on each enabled edge.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= RST_VAL;
            end
        end else if (en) begin
            data_q[0] <= in_data;
            for (int k = 1; k < DEPTH; k++) begin
                data_q[k] <= data_q[k-1];
            end
        end
    end

    // Occupancy: one in at stage 0, one out at the last stage; the pair can
    // never push the count past DEPTH or below zero.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + CW'(in_valid) - CW'(valid_q[DEPTH-1]);
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign count     = count_q;

`ifdef DFF_PIPE_PARITY_EN
    logic [DEPTH-1:0] par_q;

    // Parity chain: even parity of ingress data, optionally inverted to let
    // software exercise the checker; resets to the parity of RST_VAL.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            par_q <= {DEPTH{^RST_VAL}};
        end else if (en) begin
            par_q[0] <= (^in_data) ^ par_inject;
            for (int k = 1; k < DEPTH; k++) begin
                par_q[k] <= par_q[k-1];
            end
        end
    end

    assign parity_err = valid_q[DEPTH-1] & ((^data_q[DEPTH-1]) ^ par_q[DEPTH-1]);
`endif

endmodule

// File: tb/tb_dff_pipe_reg.sv
// Bench for dff_pipe_reg: a DEPTH=4 instance and a DEPTH=1/RST_VAL=8'h3C
// instance share stimulus; each is compared to a queue-based latency model.
module tb_dff_pipe_reg;

    logic       clk = 1'b0;
    logic       rst, en, flush, in_valid, par_inject;
    logic [7:0] in_data;

    logic       ov4, ov1;
    logic [7:0] od4, od1;
    logic [2:0] cnt4;
    logic [0:0] cnt1;
`ifdef DFF_PIPE_PARITY_EN
    logic       pe4, pe1;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dff_pipe_reg #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) dut4 (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov4), .out_data(od4), .count(cnt4)
`ifdef DFF_PIPE_PARITY_EN
        , .par_inject(par_inject), .parity_err(pe4)
`endif
    );

    dff_pipe_reg #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h3C)) dut1 (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov1), .out_data(od1), .count(cnt1)
`ifdef DFF_PIPE_PARITY_EN
        , .par_inject(par_inject), .parity_err(pe1)
`endif
    );

    // Model: a sample accepted on an enabled edge is visible exactly DEPTH
    // enabled edges later; until DEPTH edges have passed since reset/flush
    // the output shows the reset value.
    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       p;
    } ent_t;

    ent_t q4[$];
    ent_t q1[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic e, input logic v,
                        input logic [7:0] d, input logic pi);
        ent_t n, o4, o1;
        int   c4, c1;
        rst = r; flush = f; en = e; in_valid = v; in_data = d; par_inject = pi;
        @(posedge clk);
        n.v = v; n.d = d; n.p = (^d) ^ pi;
        if (r || f) begin
            q4.delete();
            q1.delete();
        end else if (e) begin
            q4.push_back(n);
            if (q4.size() > 4) void'(q4.pop_front());
            q1.push_back(n);
            if (q1.size() > 1) void'(q1.pop_front());
        end
        o4 = (q4.size() == 4) ? q4[0] : '{v: 1'b0, d: 8'h00, p: ^8'h00};
        o1 = (q1.size() == 1) ? q1[0] : '{v: 1'b0, d: 8'h3C, p: ^8'h3C};
        c4 = 0;
        foreach (q4[i]) c4 += int'(q4[i].v);
        c1 = 0;
        foreach (q1[i]) c1 += int'(q1[i].v);
        #1;
        chk("ov4", 32'(ov4), 32'(o4.v));
        chk("od4", 32'(od4), 32'(o4.d));
        chk("cnt4", 32'(cnt4), 32'(c4));
        chk("ov1", 32'(ov1), 32'(o1.v));
        chk("od1", 32'(od1), 32'(o1.d));
        chk("cnt1", 32'(cnt1), 32'(c1));
`ifdef DFF_PIPE_PARITY_EN
        chk("pe4", 32'(pe4), 32'(o4.v & ((^o4.d) ^ o4.p)));
        chk("pe1", 32'(pe1), 32'(o1.v & ((^o1.d) ^ o1.p)));
`endif
    endtask

    initial begin
        int peak;

        // Reset held two cycles while ingress is driven busy.
        step(1, 0, 1, 1, 8'hFF, 0);
        chk("rst_od4", 32'(od4), 32'h00);
        chk("rst_od1", 32'(od1), 32'h3C);
        step(1, 0, 1, 1, 8'hFF, 0);
        chk("rst_cnt4", 32'(cnt4), 32'd0);

        // Single sample followed by bubbles: visible only after the 4th edge.
        step(0, 0, 1, 1, 8'hA5, 0);
        chk("lat_ov1", 32'(ov1), 32'd1);
        chk("lat_od1", 32'(od1), 32'hA5);
        for (int i = 1; i < 6; i++) begin
            step(0, 0, 1, 0, 8'(i), 0);
            if (i == 3) chk("lat_out", 32'({ov4, od4}), 32'h1A5);
        end

        // Stream with a two-cycle stall after the third sample.
        peak = 0;
        for (int i = 1; i <= 3; i++) step(0, 0, 1, 1, 8'(i), 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 8'hEE, 0);
        for (int i = 4; i <= 6; i++) begin
            step(0, 0, 1, 1, 8'(i), 0);
            if (int'(cnt4) > peak) peak = int'(cnt4);
        end
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 8'h00, 0);
        chk("peak", 32'(peak), 32'd4);

        // Flush a full pipe; the input offered with the flush is dropped.
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 8'h10 + 8'(i), 0);
        chk("full", 32'(cnt4), 32'd4);
        step(0, 1, 1, 1, 8'hBB, 0);
        chk("fl_cnt", 32'(cnt4), 32'd0);
        chk("fl_out", 32'({ov4, od4}), 32'h000);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 8'h00, 0);

        // DEPTH=1: one-cycle latency.
        step(0, 0, 1, 1, 8'h7E, 0);
        chk("d1_out", 32'({ov1, od1}), 32'h17E);

`ifdef DFF_PIPE_PARITY_EN
        // Injected parity flags only the first of two identical samples.
        step(0, 0, 1, 1, 8'h0F, 1);
        step(0, 0, 1, 1, 8'h0F, 0);
        for (int i = 2; i < 8; i++) begin
            step(0, 0, 1, 0, 8'h00, 0);
            chk("par4", 32'(pe4), 32'(i == 3));
        end
`endif

        // Random traffic with occasional reset and flush.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
                 1'($urandom),
                 8'($urandom),
                 ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
